rx_ctrl: RTL and testbench
==========================

RX_CTRL -- requirements
Module: rx_ctrl

Interface
REQ-001 SHALL have parameter NB_PKG_W, default 8, width of byte-count fields.
REQ-002 SHALL have parameter TMO_W, default 20, width of the timeout counter.
REQ-003 SHALL have port clk  in  1  clock.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port cmd_start  in  1  one-cycle pulse that begins a receive.
REQ-006 SHALL have port cmd_abort  in  1  one-cycle pulse that cancels a receive.
REQ-007 SHALL have port cfg_nb_pkg  in  NB_PKG_W  payload byte count, sampled on cmd_start.
REQ-008 SHALL have port cfg_tmo  in  TMO_W  access-address search timeout in cycles, sampled on cmd_start.
REQ-009 SHALL have port rx_start  out  1  start/flush pulse to the RX datapath.
REQ-010 SHALL have port rx_en  out  1  RX datapath enable.
REQ-011 SHALL have ports rx_aa_found, rx_empty, rx_crc_valid  in  1 each  RX datapath status.
REQ-012 SHALL have port rx_rd_en  out  1  RX FIFO read strobe; rx_data (in, 8) is valid the cycle after it.
REQ-013 SHALL have ports out_data  out  8, out_valid  out  1, out_ready  in  1  byte stream to the consumer.
REQ-014 SHALL have ports busy  out  1, done  out  1 (one-cycle pulse), crc_ok  out  1, tmo  out  1, and byte_cnt  out  NB_PKG_W (bytes delivered).

Function
REQ-015 SHALL implement FSM states IDLE, ARM, SEARCH, READ, WAIT, CHECK.
REQ-016 SHALL go IDLE->ARM on cmd_start, clear crc_ok/tmo/byte_cnt, and latch cfg_nb_pkg and cfg_tmo.
REQ-017 SHALL assert rx_start for exactly the one ARM cycle, then enter SEARCH.
REQ-018 SHALL hold rx_en=1 in SEARCH, READ, WAIT and CHECK, and rx_en=0 in IDLE and ARM.
REQ-019 SHALL go SEARCH->READ on rx_aa_found=1.
REQ-020 SHALL, in READ, assert rx_rd_en only when rx_empty=0, out_valid=0, and no read is pending, then go to WAIT.
REQ-021 SHALL, in WAIT, load rx_data into out_data, set out_valid, and increment byte_cnt.
REQ-022 SHALL hold out_valid and out_data stable until out_valid&out_ready, then clear out_valid.
REQ-023 SHALL return WAIT->READ after the handshake while byte_cnt<nb_pkg, else go to CHECK.
REQ-024 SHALL, in CHECK, register crc_ok=rx_crc_valid, pulse done, and return to IDLE (one cycle).
REQ-025 SHALL go directly to CHECK with crc_ok=0 when nb_pkg=0 and rx_aa_found is seen.
REQ-026 SHALL, on cmd_abort in any non-IDLE state, go to IDLE next cycle with out_valid=0, done=0, crc_ok=0, and tmo unchanged.
REQ-027 SHALL ignore cmd_start while busy=1; cmd_abort takes priority over every transition.
REQ-028 SHALL drive busy=1 whenever the state is not IDLE.
REQ-029 SHALL saturate byte_cnt at nb_pkg and never issue more than nb_pkg reads per receive.

Reset
REQ-030 SHALL, on rst, force IDLE and drive all outputs to 0 asynchronously.
REQ-031 SHALL, on rst mid-receive, drop any pending FIFO read without delivering it.

Configuration
REQ-032 SHALL, with RX_CTRL_TIMEOUT_EN defined, load the down-counter with cfg_tmo on ARM and decrement it in SEARCH.
REQ-033 SHALL, with RX_CTRL_TIMEOUT_EN defined, set tmo=1, pulse done, and go to IDLE when the counter reaches 0 in SEARCH.
REQ-034 SHALL, with RX_CTRL_TIMEOUT_EN defined, treat cfg_tmo=0 as no timeout.
REQ-035 SHALL, without RX_CTRL_TIMEOUT_EN, wait in SEARCH indefinitely, tie tmo to 0, and ignore cfg_tmo.

Structure
REQ-036 SHALL place FSM state encodings and the NB_PKG_W/TMO_W defaults in the shared header.
REQ-037 SHALL use one sub-module, rx_ctrl_tmo (timeout down-counter), instantiated only under RX_CTRL_TIMEOUT_EN.

Verification
REQ-038 SHALL cover nominal receive: nb_pkg=4, aa_found after 10 cycles, FIFO bytes 11,22,33,44, crc_valid=1, out_ready=1 -> four bytes in order, byte_cnt=4, done pulse, crc_ok=1.
REQ-039 SHALL cover backpressure: out_ready=0 for 5 cycles on byte 2 -> out_data holds 0x22, no extra rx_rd_en, byte order preserved.
REQ-040 SHALL cover empty FIFO stalls: rx_empty toggling -> rx_rd_en only while rx_empty=0, final byte_cnt=nb_pkg.
REQ-041 SHALL cover timeout: cfg_tmo=100, no aa_found -> done and tmo=1 at cycle 100 after SEARCH entry (macro on); still busy at cycle 1000 (macro off).
REQ-042 SHALL cover abort: cmd_abort during READ after 2 bytes -> IDLE next cycle, out_valid=0, no done; a new cmd_start yields one rx_start pulse.
REQ-043 SHALL cover a CRC failure and reset: crc_valid=0 at CHECK -> crc_ok=0 with done; rst mid-READ -> all outputs 0 immediately.

Source files
------------

// File: rtl/rx_ctrl_pkg.sv
// rx_ctrl shared declarations: FSM encoding and default field widths.
// Imported by rx_ctrl and rx_ctrl_tmo.
package rx_ctrl_pkg;

  localparam int NB_PKG_W_DEF = 8;
  localparam int TMO_W_DEF    = 20;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARM    = 3'd1,
    SEARCH = 3'd2,
    READ   = 3'd3,
    WAIT   = 3'd4,
    CHECK  = 3'd5
  } state_t;

endpackage

// File: rtl/rx_ctrl_tmo.sv
// Access-address search timeout down-counter for rx_ctrl.
// A load value of 0 disables expiry for that receive.
module rx_ctrl_tmo
  import rx_ctrl_pkg::*;
#(
  parameter int TMO_W = TMO_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [TMO_W-1:0] i_val,
  input  logic             i_dec,
  output logic             o_expire
);

  logic [TMO_W-1:0] r_cnt;
  logic             r_act;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_act <= 1'b0;
    end else if (i_load) begin
      r_cnt <= i_val;
      r_act <= (i_val != '0);
    end else if (i_dec && r_act && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // Expire on the search cycle that would take the count to zero.
  assign o_expire = i_dec && r_act && (r_cnt == TMO_W'(1));

endmodule

// File: rtl/rx_ctrl.sv
// rx_ctrl: receive sequencer between RX datapath FIFO and a byte consumer.
// Define RX_CTRL_TIMEOUT_EN to enable the access-address search timeout.
module rx_ctrl
  import rx_ctrl_pkg::*;
#(
  parameter int NB_PKG_W = NB_PKG_W_DEF,
  parameter int TMO_W    = TMO_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_start,
  input  logic                cmd_abort,
  input  logic [NB_PKG_W-1:0] cfg_nb_pkg,
  input  logic [TMO_W-1:0]    cfg_tmo,
  output logic                rx_start,
  output logic                rx_en,
  input  logic                rx_aa_found,
  input  logic                rx_empty,
  input  logic                rx_crc_valid,
  output logic                rx_rd_en,
  input  logic [7:0]          rx_data,
  output logic [7:0]          out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy,
  output logic                done,
  output logic                crc_ok,
  output logic                tmo,
  output logic [NB_PKG_W-1:0] byte_cnt
);

  state_t              r_state;
  logic [NB_PKG_W-1:0] r_nb;
  logic [NB_PKG_W-1:0] r_cnt;
  logic                r_pend;
  logic                r_zero;
  logic [7:0]          r_data;
  logic                r_valid;
  logic                r_done;
  logic                r_crc_ok;
  logic                w_rd;
  logic                w_expire;
  logic                w_abort;

  assign w_abort = cmd_abort && (r_state != IDLE);

  assign w_rd = (r_state == READ) && !rx_empty && !r_valid
             && !r_pend && (r_cnt < r_nb) && !cmd_abort;

`ifdef RX_CTRL_TIMEOUT_EN
  logic r_tmo;

  rx_ctrl_tmo #(
    .TMO_W (TMO_W)
  ) u_tmo (
    .clk      (clk),
    .rst      (rst),
    .i_load   ((r_state == IDLE) && cmd_start),
    .i_val    (cfg_tmo),
    .i_dec    (r_state == SEARCH),
    .o_expire (w_expire)
  );

  assign tmo = r_tmo;
`else
  logic w_unused_tmo;
  assign w_unused_tmo = ^cfg_tmo;
  assign w_expire     = 1'b0;
  assign tmo          = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_nb     <= '0;
      r_cnt    <= '0;
      r_pend   <= 1'b0;
      r_zero   <= 1'b0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_done   <= 1'b0;
      r_crc_ok <= 1'b0;
`ifdef RX_CTRL_TIMEOUT_EN
      r_tmo    <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      if (w_abort) begin
        r_state  <= IDLE;
        r_valid  <= 1'b0;
        r_pend   <= 1'b0;
        r_crc_ok <= 1'b0;
      end else begin
        unique case (r_state)
          IDLE: if (cmd_start) begin
            r_state  <= ARM;
            r_nb     <= cfg_nb_pkg;
            r_cnt    <= '0;
            r_zero   <= 1'b0;
            r_crc_ok <= 1'b0;
`ifdef RX_CTRL_TIMEOUT_EN
            r_tmo    <= 1'b0;
`endif
          end
          ARM: r_state <= SEARCH;
          SEARCH: begin
            if (rx_aa_found) begin
              r_zero  <= (r_nb == '0);
              r_state <= (r_nb == '0) ? CHECK : READ;
            end else if (w_expire) begin
`ifdef RX_CTRL_TIMEOUT_EN
              r_tmo   <= 1'b1;
`endif
              r_done  <= 1'b1;
              r_state <= IDLE;
            end
          end
          READ: if (w_rd) begin
            r_pend  <= 1'b1;
            r_state <= WAIT;
          end
          // First WAIT cycle captures the FIFO byte; later ones hold it.
          WAIT: begin
            if (r_pend) begin
              r_data  <= rx_data;
              r_valid <= 1'b1;
              r_pend  <= 1'b0;
              r_cnt   <= r_cnt + 1'b1;
            end else if (r_valid && out_ready) begin
              r_valid <= 1'b0;
              r_state <= (r_cnt < r_nb) ? READ : CHECK;
            end
          end
          CHECK: begin
            r_crc_ok <= rx_crc_valid && !r_zero;
            r_done   <= 1'b1;
            r_state  <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign rx_start  = (r_state == ARM);
  assign rx_en     = (r_state != IDLE) && (r_state != ARM);
  assign busy      = (r_state != IDLE);
  assign rx_rd_en  = w_rd;
  assign out_data  = r_data;
  assign out_valid = r_valid;
  assign done      = r_done;
  assign crc_ok    = r_crc_ok;
  assign byte_cnt  = r_cnt;

endmodule

// File: tb/tb_rx_ctrl.sv
// Self-checking bench for rx_ctrl: vector table, random receives vs a
// byte-stream reference model, and directed abort/reset/timeout sequences.
module tb_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_start, cmd_abort;
  logic [7:0] cfg_nb_pkg;
  logic [19:0] cfg_tmo;
  logic       rx_start, rx_en, rx_aa_found, rx_empty, rx_crc_valid;
  logic       rx_rd_en;
  logic [7:0] rx_data, out_data;
  logic       out_valid, out_ready, busy, done, crc_ok, tmo;
  logic [7:0] byte_cnt;

  int checks = 0;
  int failures = 0;

  logic [7:0] fifo[$];
  logic [7:0] got[$];
  logic [7:0] expq[$];
  bit  stall;
  int  nreads, ndone, nstart;
  bit  prev_v, prev_r;
  logic [7:0] prev_d;

  always #5 clk = ~clk;

  rx_ctrl dut (
    .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_abort(cmd_abort),
    .cfg_nb_pkg(cfg_nb_pkg), .cfg_tmo(cfg_tmo), .rx_start(rx_start),
    .rx_en(rx_en), .rx_aa_found(rx_aa_found), .rx_empty(rx_empty),
    .rx_crc_valid(rx_crc_valid), .rx_rd_en(rx_rd_en), .rx_data(rx_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .crc_ok(crc_ok), .tmo(tmo),
    .byte_cnt(byte_cnt)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Observe handshakes, reads, pulses and stability rules each cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) got.push_back(out_data);
      if (rx_rd_en) begin
        nreads++;
        chk("rd_while_empty", int'(rx_empty), 0);
      end
      if (done) ndone++;
      if (rx_start) nstart++;
      if (prev_v && !prev_r) begin
        chk("hold_valid", int'(out_valid), 1);
        chk("hold_data", int'(out_data), int'(prev_d));
      end
    end
    prev_v = out_valid && !rst;
    prev_r = out_ready;
    prev_d = out_data;
  end

  task automatic upd_empty();
    rx_empty = stall || (fifo.size() == 0);
  endtask

  task automatic cycle();
    bit rd;
    @(negedge clk);
    rd = rx_rd_en;
    @(posedge clk);
    #1;
    if (rd && fifo.size() > 0) rx_data = fifo.pop_front();
    upd_empty();
  endtask

  task automatic run_rx(input int nb, input int aa_dly, input bit crc,
                        input int stall_pct, input int rdy_pct,
                        input int bp_at, input int bp_len);
    int hold = bp_len;
    got.delete();
    nreads = 0; ndone = 0; nstart = 0;
    cfg_nb_pkg = 8'(nb);
    cfg_tmo = '0;
    rx_crc_valid = crc;
    cmd_start = 1'b1;
    cycle();
    cmd_start = 1'b0;
    for (int c = 0; c < 800 && ndone == 0; c++) begin
      rx_aa_found = (c >= aa_dly);
      stall = ($urandom_range(99, 0) < stall_pct);
      upd_empty();
      if (hold > 0 && got.size() == bp_at && out_valid) begin
        out_ready = 1'b0;
        hold--;
        chk("bp_data", int'(out_data), int'(expq[bp_at]));
      end else begin
        out_ready = ($urandom_range(99, 0) < rdy_pct);
      end
      cycle();
    end
    rx_aa_found = 1'b0;
    out_ready = 1'b0;
    stall = 1'b0;
    upd_empty();
    cycle();
    chk("done_pulses", ndone, 1);
    chk("rx_start_pulses", nstart, 1);
    chk("busy_end", int'(busy), 0);
    chk("byte_cnt", int'(byte_cnt), nb);
    chk("crc_ok", int'(crc_ok), int'(crc && nb != 0));
    chk("tmo_end", int'(tmo), 0);
    chk("reads", nreads, nb);
    chk("bytes_out", got.size(), nb);
    for (int i = 0; i < nb && i < got.size(); i++)
      chk($sformatf("byte%0d", i), int'(got[i]), int'(expq[i]));
  endtask

  // Reference: the consumer sees the first nb FIFO bytes in order.
  task automatic load_fifo(input int nb, input bit rnd);
    fifo.delete();
    expq.delete();
    for (int i = 0; i < nb + 2; i++) begin
      logic [7:0] b;
      b = rnd ? 8'($urandom) : 8'((i + 1) * 8'h11);
      fifo.push_back(b);
      if (i < nb) expq.push_back(b);
    end
    upd_empty();
  endtask

  typedef struct {
    int nb; int aa; bit crc; int stall; int rdy; int bp_at; int bp_len;
  } vec_t;

  vec_t vt[6];

  initial begin
    int n;
    vt[0] = '{4, 10, 1'b1, 0, 100, 0, 0};
    vt[1] = '{4, 3, 1'b1, 0, 100, 1, 5};
    vt[2] = '{6, 5, 1'b1, 60, 100, 0, 0};
    vt[3] = '{4, 3, 1'b0, 0, 100, 0, 0};
    vt[4] = '{0, 2, 1'b1, 0, 100, 0, 0};
    vt[5] = '{1, 0, 1'b1, 30, 60, 0, 0};

    rst = 1'b1; cmd_start = 0; cmd_abort = 0; cfg_nb_pkg = 0;
    cfg_tmo = 0; rx_aa_found = 0; rx_crc_valid = 0; out_ready = 0;
    rx_data = 0; stall = 0; rx_empty = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_outs", int'({rx_start, rx_en, rx_rd_en, out_valid, done,
                          crc_ok, tmo}), 0);
    chk("rst_cnt", int'(byte_cnt), 0);
    rst = 1'b0;
    cycle();

    for (int v = 0; v < 6; v++) begin
      load_fifo(vt[v].nb, 1'b0);
      run_rx(vt[v].nb, vt[v].aa, vt[v].crc, vt[v].stall, vt[v].rdy,
             vt[v].bp_at, vt[v].bp_len);
    end

    for (int r = 0; r < 25; r++) begin
      n = $urandom_range(6, 0);
      load_fifo(n, 1'b1);
      run_rx(n, $urandom_range(8, 0), 1'($urandom), $urandom_range(60, 0),
             $urandom_range(100, 30), 0, 0);
    end

    // Abort in READ after two bytes, then restart.
    load_fifo(4, 1'b0);
    got.delete(); nreads = 0; ndone = 0;
    cfg_nb_pkg = 4; rx_aa_found = 1; out_ready = 1; rx_crc_valid = 1;
    cmd_start = 1; cycle(); cmd_start = 0;
    for (int c = 0; c < 100 && got.size() < 2; c++) cycle();
    chk("abort_pre_busy", int'(busy), 1);
    cmd_abort = 1; cycle(); cmd_abort = 0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_valid", int'(out_valid), 0);
    chk("abort_crc", int'(crc_ok), 0);
    repeat (5) cycle();
    chk("abort_no_done", ndone, 0);
    chk("abort_reads", nreads, 2);

    // Restart, then reset with a FIFO read in flight.
    load_fifo(4, 1'b0);
    got.delete(); nstart = 0;
    cmd_start = 1; cycle(); cmd_start = 0;
    for (int c = 0; c < 100 && !rx_rd_en; c++) cycle();
    chk("restart_start", nstart, 1);
    chk("restart_rd", int'(rx_rd_en), 1);
    cycle();
    rst = 1'b1;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_outs", int'({rx_start, rx_en, rx_rd_en, out_valid, done,
                             crc_ok, tmo}), 0);
    chk("midrst_cnt", int'(byte_cnt), 0);
    cycle();
    rst = 1'b0;
    repeat (4) cycle();
    chk("midrst_no_byte", got.size(), 0);
    rx_aa_found = 0;

    // Access-address search timeout.
    ndone = 0;
    cfg_nb_pkg = 4; cfg_tmo = 20'd100;
    cmd_start = 1; cycle(); cmd_start = 0;
    cycle();
    chk("search_en", int'(rx_en), 1);
`ifdef RX_CTRL_TIMEOUT_EN
    repeat (99) cycle();
    chk("tmo_early_done", int'(done), 0);
    chk("tmo_early_busy", int'(busy), 1);
    cycle();
    chk("tmo_done", int'(done), 1);
    chk("tmo_flag", int'(tmo), 1);
    chk("tmo_busy", int'(busy), 0);
`else
    repeat (1000) cycle();
    chk("notmo_busy", int'(busy), 1);
    chk("notmo_flag", int'(tmo), 0);
    chk("notmo_done", ndone, 0);
    cmd_abort = 1; cycle(); cmd_abort = 0;
    chk("notmo_abort", int'(busy), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
